// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: 4-entry in-order prediction FIFO checked against EX resolutions, with flush/redirect on mispredict.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
module branch_resolve_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [31:0] pred_addr,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] res_pc_plus4,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [2:0]  fifo_count,
  output logic        underflow_err,
  output logic [31:0] br_count,
  output logic [31:0] mis_count
);

  typedef enum logic {NORMAL, FLUSH} state_t;

  state_t      state;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic        fifo_taken [4];
  logic [31:0] fifo_addr  [4];

  logic        head_taken;
  logic [31:0] head_addr;
  logic [31:0] actual_next;
  logic        do_push;
  logic        do_pop;
  logic        mispredict;

  always_comb begin
    pred_ready  = (fifo_count < 3'd4) && (state == NORMAL);
    head_taken  = fifo_taken[rd_ptr];
    head_addr   = fifo_addr[rd_ptr];
    actual_next = res_taken ? res_target : res_pc_plus4;
    do_push     = pred_valid && pred_ready;
    do_pop      = res_valid && (state == NORMAL) && (fifo_count != 3'd0);
    mispredict  = do_pop &&
                  ((head_taken != res_taken) || (res_taken && (head_addr != res_target)));
  end

  // Payload storage needs no reset: fifo_count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !mispredict) begin
      fifo_taken[wr_ptr] <= pred_taken;
      fifo_addr[wr_ptr]  <= pred_addr;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state         <= NORMAL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      underflow_err <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          flush <= 1'b0;
          if (mispredict) begin
            // Squash everything in flight, including any coincident push.
            state       <= FLUSH;
            flush       <= 1'b1;
            redirect_pc <= actual_next;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
          end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + 3'(do_push) - 3'(do_pop);
          end
          if (res_valid && (fifo_count == 3'd0)) underflow_err <= 1'b1;
        end
        FLUSH: begin
          state <= NORMAL;
          flush <= 1'b0;
        end
        default: begin
          state <= NORMAL;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      br_count  <= '0;
      mis_count <= '0;
    end else begin
      if (do_pop && (br_count != '1))      br_count  <= br_count + 32'd1;
      if (mispredict && (mis_count != '1)) mis_count <= mis_count + 32'd1;
    end
  end
`else
  assign br_count  = '0;
  assign mis_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: queue-based reference model checked every negedge, plus literal spot checks.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_addr = '0;
  logic        pred_ready;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] res_target = '0, res_pc_plus4 = '0;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
  logic        underflow_err;
  logic [31:0] br_count, mis_count;

  int n_total = 0;
  int n_pass  = 0;

`ifdef BRU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  branch_resolve_unit dut (
    .clk(clk), .Reset(Reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_addr(pred_addr), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target), .res_pc_plus4(res_pc_plus4),
    .flush(flush), .redirect_pc(redirect_pc), .fifo_count(fifo_count),
    .underflow_err(underflow_err), .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: in-flight predictions as a queue.
  typedef struct packed { logic t; logic [31:0] a; } ent_t;
  ent_t        q[$];
  bit          m_flush;
  logic [31:0] m_redir;
  bit          m_uf;
  logic [31:0] m_br, m_mis;

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      q.delete();
      m_flush = 0; m_redir = '0; m_uf = 0; m_br = '0; m_mis = '0;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      bit can_push, bad;
      logic [31:0] actual;
      can_push = (q.size() < 4);
      bad = 0;
      if (res_valid) begin
        if (q.size() == 0) m_uf = 1;
        else begin
          actual = res_taken ? res_target : res_pc_plus4;
          bad = (q[0].t != res_taken) || (res_taken && q[0].a != res_target);
          if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
          if (bad) begin
            if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            q.delete();
            m_flush = 1;
            m_redir = actual;
          end else void'(q.pop_front());
        end
      end
      if (pred_valid && can_push && !bad) q.push_back('{pred_taken, pred_addr});
    end
  end

  always @(negedge clk) begin
    chk("m_flush",    {31'd0, flush},         {31'd0, m_flush});
    chk("m_redirect", redirect_pc,            m_redir);
    chk("m_count",    {29'd0, fifo_count},    q.size());
    chk("m_ready",    {31'd0, pred_ready},    {31'd0, (!m_flush && q.size() < 4)});
    chk("m_uflow",    {31'd0, underflow_err}, {31'd0, m_uf});
    chk("m_br",       br_count,               STATS ? m_br : 32'd0);
    chk("m_mis",      mis_count,              STATS ? m_mis : 32'd0);
  end

  task automatic cyc(input bit pv, input bit pt, input logic [31:0] pa,
                     input bit rv, input bit rt, input logic [31:0] rtg, input logic [31:0] rp4);
    pred_valid = pv; pred_taken = pt; pred_addr = pa;
    res_valid = rv; res_taken = rt; res_target = rtg; res_pc_plus4 = rp4;
    @(posedge clk); #1;
    pred_valid = 0; res_valid = 0;
  endtask

  task automatic push(input bit t, input logic [31:0] a);
    cyc(1, t, a, 0, 0, '0, '0);
  endtask

  task automatic resolve(input bit t, input logic [31:0] tgt, input logic [31:0] p4);
    cyc(0, 0, '0, 1, t, tgt, p4);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 Reset = 0;
    @(negedge clk); #1;
    chk("rst_ready", {31'd0, pred_ready}, 32'd1);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);

    // Correct taken prediction
    push(1, 32'h100);
    chk("c_cnt1", {29'd0, fifo_count}, 32'd1);
    resolve(1, 32'h100, 32'h8);
    chk("c_flush", {31'd0, flush}, 32'd0);
    chk("c_cnt0", {29'd0, fifo_count}, 32'd0);
    chk("c_br", br_count, STATS ? 32'd1 : 32'd0);

    // Direction mispredict, taken actual
    push(0, 32'h4);
    resolve(1, 32'h200, 32'h8);
    chk("m1_flush", {31'd0, flush}, 32'd1);
    chk("m1_redir", redirect_pc, 32'h200);
    chk("m1_cnt", {29'd0, fifo_count}, 32'd0);
    chk("m1_mis", mis_count, STATS ? 32'd1 : 32'd0);
    cyc(0, 0, '0, 0, 0, '0, '0);
    chk("m1_pulse", {31'd0, flush}, 32'd0);
    chk("m1_hold", redirect_pc, 32'h200);

    // Predicted taken, actually not taken
    push(1, 32'h300);
    resolve(0, 32'h300, 32'h44);
    chk("m2_flush", {31'd0, flush}, 32'd1);
    chk("m2_redir", redirect_pc, 32'h44);
    cyc(0, 0, '0, 0, 0, '0, '0);

    // Fill, overflow drop, then push+pop at count 3
    for (int i = 0; i < 4; i++) push(1, 32'h10 + i);
    chk("full_cnt", {29'd0, fifo_count}, 32'd4);
    chk("full_rdy", {31'd0, pred_ready}, 32'd0);
    push(1, 32'h99);
    chk("drop_cnt", {29'd0, fifo_count}, 32'd4);
    resolve(1, 32'h10, 32'h0);
    chk("pop_cnt3", {29'd0, fifo_count}, 32'd3);
    cyc(1, 1, 32'h20, 1, 1, 32'h11, 32'h0);
    chk("pp_cnt3", {29'd0, fifo_count}, 32'd3);
    resolve(1, 32'h12, 32'h0);
    resolve(1, 32'h13, 32'h0);
    resolve(1, 32'h20, 32'h0);
    chk("drain_flush", {31'd0, flush}, 32'd0);
    chk("drain_cnt", {29'd0, fifo_count}, 32'd0);

    // Push coincident with mispredict is discarded; inputs ignored during flush
    push(1, 32'h50);
    cyc(1, 1, 32'h60, 1, 0, 32'h0, 32'h54);
    chk("mp_redir", redirect_pc, 32'h54);
    chk("mp_cnt", {29'd0, fifo_count}, 32'd0);
    cyc(1, 1, 32'h70, 1, 1, 32'h70, 32'h0);
    chk("fl_ign_cnt", {29'd0, fifo_count}, 32'd0);
    chk("fl_ign_uf", {31'd0, underflow_err}, 32'd0);

    // Underflow is sticky
    resolve(1, 32'h80, 32'h84);
    chk("uf_set", {31'd0, underflow_err}, 32'd1);
    chk("uf_flush", {31'd0, flush}, 32'd0);
    repeat (3) cyc(0, 0, '0, 0, 0, '0, '0);
    push(1, 32'h90);
    resolve(1, 32'h90, 32'h0);
    chk("uf_sticky", {31'd0, underflow_err}, 32'd1);

    // Reset during flush
    push(0, 32'h0);
    resolve(1, 32'h400, 32'h4);
    chk("rf_flush1", {31'd0, flush}, 32'd1);
    #2 Reset = 1;
    #1;
    chk("rf_flush0", {31'd0, flush}, 32'd0);
    chk("rf_cnt", {29'd0, fifo_count}, 32'd0);
    chk("rf_redir", redirect_pc, 32'd0);
    chk("rf_uf", {31'd0, underflow_err}, 32'd0);
    @(negedge clk); #2 Reset = 0;
    @(negedge clk); #1;
    chk("rf_noredir", {31'd0, flush}, 32'd0);
    chk("rf_ready", {31'd0, pred_ready}, 32'd1);
    repeat (3) cyc(0, 0, '0, 0, 0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port clk  input  1  core clock; all state updates on posedge.
REQ-002 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port pred_valid  input  1  new prediction from predictor stage.
REQ-004 SHALL have port pred_taken  input  1  predicted direction.
REQ-005 SHALL have port pred_addr  input  32  predicted next PC.
REQ-006 SHALL have port pred_ready  output  1  FIFO can accept a prediction.
REQ-007 SHALL have port res_valid  input  1  oldest in-flight branch resolved in EX.
REQ-008 SHALL have port res_taken  input  1  actual direction.
REQ-009 SHALL have port res_target  input  32  actual taken target.
REQ-010 SHALL have port res_pc_plus4  input  32  fall-through address of resolved branch.
REQ-011 SHALL have port flush  output  1  one-cycle pipeline squash pulse.
REQ-012 SHALL have port redirect_pc  output  32  corrected fetch address, valid while flush=1.
REQ-013 SHALL have port fifo_count  output  3  in-flight predictions, 0..4.
REQ-014 SHALL have port underflow_err  output  1  sticky: resolve with empty FIFO.
REQ-015 SHALL have ports br_count and mis_count  output  32 each  statistics (see Configuration).

Function
REQ-016 SHALL hold a 4-entry in-order FIFO of {pred_taken, pred_addr}.
REQ-017 SHALL drive pred_ready = (fifo_count < 4) AND (state == NORMAL), combinationally.
REQ-018 SHALL push on posedge when pred_valid AND pred_ready; pred_valid while pred_ready=0 is dropped, no error.
REQ-019 SHALL pop head on posedge when res_valid, state NORMAL, FIFO non-empty.
REQ-020 SHALL compute actual_next = res_taken ? res_target : res_pc_plus4.
REQ-021 SHALL declare mispredict when head.pred_taken != res_taken, or res_taken=1 and head.pred_addr != res_target.
REQ-022 SHALL implement states NORMAL and FLUSH; NORMAL -> FLUSH on popped mispredict; FLUSH -> NORMAL unconditionally after one cycle.
REQ-023 SHALL, on mispredict edge: register redirect_pc = actual_next, set flush=1 for exactly the following cycle, empty FIFO (fifo_count=0).
REQ-024 SHALL discard a push coincident with a mispredicting pop.
REQ-025 SHALL, on a coincident push and correct pop, leave fifo_count unchanged with new entry at tail.
REQ-026 SHALL ignore res_valid and pred_valid during FLUSH.
REQ-027 SHALL, on res_valid in NORMAL with empty FIFO, set underflow_err=1 until Reset; no flush, no pop.
REQ-028 SHALL hold redirect_pc at its last value when flush=0.
REQ-029 SHALL wrap FIFO read/write pointers modulo 4.

Reset
REQ-030 SHALL, on Reset asserted at any time, immediately force: state NORMAL, fifo_count 0, pointers 0, flush 0, redirect_pc 0, underflow_err 0, br_count 0, mis_count 0.
REQ-031 SHALL, on Reset during FLUSH, deassert flush asynchronously; no redirect issued after Reset release.
REQ-032 SHALL present pred_ready=1 in first cycle after Reset release.

Configuration
REQ-033 SHALL, with BRU_STATS_EN defined, increment br_count per accepted pop and mis_count per mispredict, both saturating at 32'hFFFFFFFF.
REQ-034 SHALL, without BRU_STATS_EN, keep br_count and mis_count ports, tied to 0, no counter flops.

Verification
REQ-035 SHALL test: push {taken=1, addr=0x100}; resolve taken=1, target=0x100 -> flush stays 0, fifo_count 1->0, br_count=1.
REQ-036 SHALL test: push {taken=0}; resolve taken=1, target=0x200 -> next cycle flush=1, redirect_pc=0x200, fifo_count=0, mis_count=1.
REQ-037 SHALL test: push {taken=1, addr=0x300}; resolve taken=0, pc_plus4=0x44 -> flush=1, redirect_pc=0x44.
REQ-038 SHALL test: 4 pushes then 5th pred_valid -> pred_ready=0, fifo_count=4, 5th dropped; then push+correct pop same cycle at count 3 -> count stays 3.
REQ-039 SHALL test: res_valid with empty FIFO -> underflow_err=1, flush=0; stays 1 until Reset.
REQ-040 SHALL test: Reset asserted during flush cycle -> flush=0 immediately, fifo_count=0, redirect_pc=0.
